// File: rtl/axil_wr_rd_checker.sv
// AXI4-Lite write / read-back / compare register self-test master.
// Define AXIL_CHK_HALT_ON_ERR_EN to end the run after the first failing vector.
module axil_wr_rd_checker #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    NUM_VECTORS    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    ADDR_STRIDE    = 4,
  parameter int                    TIMEOUT_CYCLES = 256,
  localparam int IDX_W  = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
  localparam int STRB_W = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  vec_wr_en,
  input  logic [IDX_W-1:0]      vec_wr_idx,
  input  logic [DATA_WIDTH-1:0] vec_wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic                  timeout,
  output logic [IDX_W-1:0]      first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_rdata,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_W-1:0]     m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_FIN   = 3'd7;

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] vec_q [NUM_VECTORS];
  logic [DATA_WIDTH-1:0] vec_d [NUM_VECTORS];
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  timeout_q, timeout_d;
  logic [IDX_W-1:0]      fe_idx_q, fe_idx_d;
  logic [DATA_WIDTH-1:0] fe_rdata_q, fe_rdata_d;
  logic                  pass_q, pass_d;

  logic                  aw_hs, w_hs, tmo_hit, idx_last;
  logic                  err_ev, err_ok, halt;
  logic [DATA_WIDTH-1:0] err_data;

  assign aw_hs    = m_axi_awvalid && m_axi_awready;
  assign w_hs     = m_axi_wvalid && m_axi_wready;
  assign tmo_hit  = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign idx_last = (32'(idx_q) == NUM_VECTORS - 1);

`ifdef AXIL_CHK_HALT_ON_ERR_EN
  assign err_ok = (err_cnt_q == 8'd0);
  assign halt   = (err_cnt_q != 8'd0);
`else
  assign err_ok = 1'b1;
  assign halt   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
    rdata_d    = rdata_q;
    vec_d      = vec_q;
    err_cnt_d  = err_cnt_q;
    timeout_d  = timeout_q;
    fe_idx_d   = fe_idx_q;
    fe_rdata_d = fe_rdata_q;
    pass_d     = pass_q;
    err_ev     = 1'b0;
    err_data   = '0;

    unique case (state_q)
      S_IDLE: begin
        tmo_cnt_d = '0;
        if (vec_wr_en && (32'(vec_wr_idx) < NUM_VECTORS))
          vec_d[vec_wr_idx] = vec_wr_data;
        if (start) begin
          idx_d      = '0;
          err_cnt_d  = '0;
          timeout_d  = 1'b0;
          fe_idx_d   = '0;
          fe_rdata_d = '0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = S_WR;
        end
      end
      S_WR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          tmo_cnt_d = '0;
          state_d   = S_WRESP;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          err_ev    = 1'b1;
          state_d   = S_FIN;
        end
      end
      S_WRESP: begin
        if (m_axi_bvalid) begin
          err_ev    = (m_axi_bresp != 2'b00);
          tmo_cnt_d = '0;
          state_d   = S_RD;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          err_ev    = 1'b1;
          state_d   = S_FIN;
        end
      end
      S_RD: begin
        if (m_axi_arready) begin
          tmo_cnt_d = '0;
          state_d   = S_RDATA;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          err_ev    = 1'b1;
          state_d   = S_FIN;
        end
      end
      S_RDATA: begin
        if (m_axi_rvalid) begin
          rdata_d  = m_axi_rdata;
          err_ev   = (m_axi_rresp != 2'b00);
          err_data = m_axi_rdata;
          state_d  = S_CHECK;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          err_ev    = 1'b1;
          state_d   = S_FIN;
        end
      end
      S_CHECK: begin
        err_ev   = (rdata_q != vec_q[idx_q]);
        err_data = rdata_q;
        state_d  = S_NEXT;
      end
      S_NEXT: begin
        tmo_cnt_d = '0;
        if (idx_last || halt) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_WR;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Only the first error of a run pins the first_err_* capture.
    if (err_ev && err_ok) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      if (err_cnt_q == 8'd0) begin
        fe_idx_d   = idx_q;
        fe_rdata_d = err_data;
      end
    end

    if (state_d == S_FIN && state_q != S_FIN)
      pass_d = (err_cnt_d == 8'd0);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      tmo_cnt_q  <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < NUM_VECTORS; i++) vec_q[i] <= '0;
      err_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      fe_idx_q   <= '0;
      fe_rdata_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rdata_q    <= rdata_d;
      vec_q      <= vec_d;
      err_cnt_q  <= err_cnt_d;
      timeout_q  <= timeout_d;
      fe_idx_q   <= fe_idx_d;
      fe_rdata_q <= fe_rdata_d;
      pass_q     <= pass_d;
    end
  end

  assign busy            = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done            = (state_q == S_FIN);
  assign pass            = pass_q;
  assign err_count       = err_cnt_q;
  assign timeout         = timeout_q;
  assign first_err_idx   = fe_idx_q;
  assign first_err_rdata = fe_rdata_q;

  assign m_axi_awaddr  = BASE_ADDR
                       + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(ADDR_STRIDE);
  assign m_axi_araddr  = m_axi_awaddr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = vec_q[idx_q];
  assign m_axi_awvalid = (state_q == S_WR) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == S_WR) && !w_done_q;
  assign m_axi_bready  = (state_q == S_WRESP);
  assign m_axi_arvalid = (state_q == S_RD);
  assign m_axi_rready  = (state_q == S_RDATA);

endmodule

// File: tb/tb_axil_wr_rd_checker.sv
// Bench for axil_wr_rd_checker: fault-injecting register-file slave,
// queue-based expectation model and a per-cycle compare process.
module tb_axil_wr_rd_checker;

  logic        clk = 1'b0;
  logic        ARESET;
  logic        vec_wr_en;
  logic [1:0]  vec_wr_idx;
  logic [31:0] vec_wr_data;
  logic        start;
  logic        busy, done, pass, timeout;
  logic [7:0]  err_count;
  logic [1:0]  first_err_idx;
  logic [31:0] first_err_rdata;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  always #5 clk = ~clk;

  axil_wr_rd_checker #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(clk), .ARESET(ARESET),
    .vec_wr_en(vec_wr_en), .vec_wr_idx(vec_wr_idx),
    .vec_wr_data(vec_wr_data), .start(start),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .timeout(timeout), .first_err_idx(first_err_idx),
    .first_err_rdata(first_err_rdata),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, got, exp);
    end
  endtask

  // ---------------- slave ----------------
  logic [31:0] mem [16];
  int cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
  int stuck_reg = -1, bad_b = -1, bad_r = -1;
  bit rand_dly = 0, no_b = 0;
  int aw_rnd, w_rnd, b_rnd, ar_rnd, r_rnd;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int eaw, ew, eb, ear, er;
  logic aw_got, w_got, b_pend, r_pend, aw_now, w_now;
  logic [31:0] aw_a, w_d, b_a, r_a;

  assign eaw = rand_dly ? aw_rnd : cfg_aw;
  assign ew  = rand_dly ? w_rnd  : cfg_w;
  assign eb  = rand_dly ? b_rnd  : cfg_b;
  assign ear = rand_dly ? ar_rnd : cfg_ar;
  assign er  = rand_dly ? r_rnd  : cfg_r;

  assign m_axi_awready = m_axi_awvalid && !aw_got && aw_cnt >= eaw;
  assign m_axi_wready  = m_axi_wvalid && !w_got && w_cnt >= ew;
  assign m_axi_bvalid  = b_pend && !no_b && b_cnt >= eb;
  assign m_axi_bresp   = (int'(b_a[5:2]) == bad_b) ? 2'b10 : 2'b00;
  assign m_axi_arready = m_axi_arvalid && ar_cnt >= ear;
  assign m_axi_rvalid  = r_pend && r_cnt >= er;
  assign m_axi_rresp   = (int'(r_a[5:2]) == bad_r) ? 2'b10 : 2'b00;
  assign m_axi_rdata   = mem[r_a[5:2]]
                       & ((int'(r_a[5:2]) == stuck_reg) ? 32'h7FFF_FFFF
                                                        : 32'hFFFF_FFFF);
  assign aw_now = aw_got || (m_axi_awvalid && m_axi_awready);
  assign w_now  = w_got || (m_axi_wvalid && m_axi_wready);

  function automatic int nd();
    return int'($urandom_range(0, 4));
  endfunction

  always @(posedge clk) begin
    if (ARESET) begin
      aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_rnd <= 0; w_rnd <= 0; b_rnd <= 0; ar_rnd <= 0; r_rnd <= 0;
      b_a <= '0; r_a <= '0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        aw_got <= 1; aw_a <= m_axi_awaddr; aw_cnt <= 0; aw_rnd <= nd();
      end else if (m_axi_awvalid) aw_cnt <= aw_cnt + 1;
      if (m_axi_wvalid && m_axi_wready) begin
        w_got <= 1; w_d <= m_axi_wdata; w_cnt <= 0; w_rnd <= nd();
      end else if (m_axi_wvalid) w_cnt <= w_cnt + 1;
      if (aw_now && w_now && !b_pend) begin
        mem[aw_got ? aw_a[5:2] : m_axi_awaddr[5:2]]
          <= w_got ? w_d : m_axi_wdata;
        b_a <= aw_got ? aw_a : m_axi_awaddr;
        b_pend <= 1; b_cnt <= 0; aw_got <= 0; w_got <= 0;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pend <= 0; b_rnd <= nd();
      end else if (b_pend) b_cnt <= b_cnt + 1;
      if (m_axi_arvalid && m_axi_arready) begin
        r_pend <= 1; r_a <= m_axi_araddr; r_cnt <= 0;
        ar_cnt <= 0; ar_rnd <= nd();
      end else if (m_axi_arvalid) ar_cnt <= ar_cnt + 1;
      if (m_axi_rvalid && m_axi_rready) begin
        r_pend <= 0; r_rnd <= nd();
      end else if (r_pend) r_cnt <= r_cnt + 1;
    end
  end

  // ---------------- model ----------------
  logic [31:0] vec_m [4];
  logic [31:0] exp_addr[$], exp_wdata[$], exp_raddr[$];
  int exp_err, exp_fidx;
  bit exp_pass, exp_to, chk_frd;
  logic [31:0] exp_frd;
  int run_id = 0;
  bit run_active = 0;

  task automatic build_model();
    logic [31:0] rd;
    bit e_b, e_r, e_m;
    int n;
    exp_addr.delete(); exp_wdata.delete(); exp_raddr.delete();
    exp_err = 0; exp_fidx = 0; exp_to = 0; chk_frd = 0; exp_frd = 0;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(32'(i * 4));
      exp_wdata.push_back(vec_m[i]);
      if (no_b) begin
        exp_to = 1; exp_err = 1; exp_fidx = i;
        break;
      end
      exp_raddr.push_back(32'(i * 4));
      rd  = (i == stuck_reg) ? (vec_m[i] & 32'h7FFF_FFFF) : vec_m[i];
      e_b = (i == bad_b);
      e_r = (i == bad_r);
      e_m = (rd != vec_m[i]);
      n   = int'(e_b) + int'(e_r) + int'(e_m);
      if (n > 0 && exp_err == 0) begin
        exp_fidx = i; chk_frd = !e_b; exp_frd = rd;
      end
`ifdef AXIL_CHK_HALT_ON_ERR_EN
      if (n > 0) begin
        exp_err = 1;
        break;
      end
`else
      exp_err += n;
`endif
    end
    exp_pass = (exp_err == 0);
  endtask

  // ---------------- compare ----------------
  int aw_p, w_p, ar_p, seen_id = 0;

  always begin
    @(posedge clk);
    #1;
    if (!ARESET) begin
      chk("awprot", m_axi_awprot, 0);
      chk("arprot", m_axi_arprot, 0);
      chk("wstrb", m_axi_wstrb, 4'hF);
      if (seen_id != run_id) begin
        seen_id = run_id; aw_p = 0; w_p = 0; ar_p = 0;
      end
      if (run_active) begin
        if (m_axi_awvalid && m_axi_awready) begin
          if (aw_p < exp_addr.size()) chk("awaddr", m_axi_awaddr, exp_addr[aw_p]);
          else chk("aw_count", aw_p + 1, exp_addr.size());
          aw_p++;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          if (w_p < exp_wdata.size()) chk("wdata", m_axi_wdata, exp_wdata[w_p]);
          else chk("w_count", w_p + 1, exp_wdata.size());
          w_p++;
        end
        if (m_axi_arvalid && m_axi_arready) begin
          if (ar_p < exp_raddr.size()) chk("araddr", m_axi_araddr, exp_raddr[ar_p]);
          else chk("ar_count", ar_p + 1, exp_raddr.size());
          ar_p++;
        end
        if (done) begin
          chk("err_count", err_count, exp_err);
          chk("pass", pass, exp_pass);
          chk("timeout", timeout, exp_to);
          if (exp_err > 0) chk("first_err_idx", first_err_idx, exp_fidx);
          if (chk_frd) chk("first_err_rdata", first_err_rdata, exp_frd);
          chk("aw_total", aw_p, exp_addr.size());
          chk("w_total", w_p, exp_wdata.size());
          chk("ar_total", ar_p, exp_raddr.size());
          chk("busy_at_done", busy, 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load(input int i, input logic [31:0] d);
    @(negedge clk);
    vec_wr_en = 1; vec_wr_idx = 2'(i); vec_wr_data = d; vec_m[i] = d;
    @(negedge clk);
    vec_wr_en = 0;
  endtask

  task automatic run(input bit chk_lat, input bit meddle, input bit chk_tmo);
    int lat, b_ent;
    build_model();
    run_id++;
    run_active = 1;
    @(negedge clk); start = 1;
    @(negedge clk);
    lat = 0; b_ent = -1;
    while (lat < 3000) begin
      lat++;
      if (lat == 1) chk("busy_after_start", busy, 1);
      if (m_axi_bready && b_ent < 0) b_ent = lat;
      if (done) break;
      if (meddle && lat == 1) begin
        start = 1; vec_wr_en = 1;
        vec_wr_idx = 2'($urandom); vec_wr_data = $urandom;
      end else begin
        start = 0; vec_wr_en = 0;
      end
      @(negedge clk);
    end
    start = 0; vec_wr_en = 0;
    chk("done_seen", done, 1);
    if (chk_lat) chk("latency", lat, 25);
    if (chk_tmo) begin
      chk("wresp_to_done", lat - b_ent, 16);
      chk("bready_at_done", m_axi_bready, 0);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("bready_idle", m_axi_bready, 0);
    run_active = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); ARESET = 1;
    @(negedge clk); @(negedge clk); ARESET = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    ARESET = 1; start = 0; vec_wr_en = 0; vec_wr_idx = 0; vec_wr_data = 0;
    for (int i = 0; i < 4; i++) vec_m[i] = 0;
    repeat (3) @(negedge clk);
    ARESET = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_fidx", first_err_idx, 0);
    chk("rst_frdata", first_err_rdata, 0);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
    chk("rst_readies", {m_axi_bready, m_axi_rready}, 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    chk("rst_wdata", m_axi_wdata, 0);

    load(0, 32'h0101FFFF); load(1, 32'hABCD0001);
    load(2, 32'hDEAD0011); load(3, 32'hBEEF0011);
    run(1, 0, 0);
    chk("t1_err_lit", err_count, 0);
    chk("t1_pass_lit", pass, 1);

    stuck_reg = 2;
    run(0, 0, 0);
    chk("t2_err_lit", err_count, 1);
    chk("t2_fidx_lit", first_err_idx, 2);
    chk("t2_frd_lit", first_err_rdata, 32'h5EAD0011);
    chk("t2_pass_lit", pass, 0);
    stuck_reg = -1;

    cfg_w = 3; cfg_ar = 5;
    run(0, 0, 0);
    chk("t3_pass_lit", pass, 1);
    cfg_w = 0; cfg_ar = 0;

    bad_b = 1;
    run(0, 0, 0);
    chk("t4_err_lit", err_count, 1);
    chk("t4_pass_lit", pass, 0);
    bad_b = -1;

    no_b = 1;
    run(0, 0, 1);
    chk("t5_timeout_lit", timeout, 1);
    no_b = 0;
    pulse_reset();
    for (int i = 0; i < 4; i++) vec_m[i] = 0;
    load(0, 32'h1234_5678); load(1, 32'h8765_4321);
    load(2, 32'hCAFE_F00D); load(3, 32'h0BAD_BEEF);

    cfg_r = 3;
    build_model();
    run_id++;
    run_active = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    w = 0;
    while (!m_axi_rready && w < 200) begin
      @(negedge clk); w++;
    end
    chk("t6_reached_rdata", m_axi_rready, 1);
    ARESET = 1;
    @(posedge clk); #1;
    chk("t6_busy", busy, 0);
    chk("t6_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
    chk("t6_readies", {m_axi_bready, m_axi_rready}, 0);
    run_active = 0;
    @(negedge clk); ARESET = 0;
    cfg_r = 0;
    for (int i = 0; i < 4; i++) vec_m[i] = 0;
    load(1, 32'h5555_AAAA);
    run(1, 0, 0);
    chk("t6_pass_lit", pass, 1);

    rand_dly = 1;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) load(i, $urandom);
      stuck_reg = int'($urandom_range(0, 5));
      bad_b     = int'($urandom_range(0, 7));
      bad_r     = int'($urandom_range(0, 7));
      if (stuck_reg > 3) stuck_reg = -1;
      if (bad_b > 3) bad_b = -1;
      if (bad_r > 3) bad_r = -1;
      run(0, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_wr_rd_checker.md
Name: axil_wr_rd_checker

Overview:
- Synthesizable AXI4-Lite master that runs an on-chip register self-test of the tsl235r slave (or any AXI4-Lite slave).
- For each of NUM_VECTORS programmable vectors it does three things: writes the vector, reads it back from the same address, and compares the two.
- Generalises the write/readback/compare test flow to parametrised width, depth, address stride and timeout, with counted (non-fatal) errors.
- Sits between the PS/control fabric (start, status) and the slave's AXI4-Lite port.

Parameters:
- DATA_WIDTH, 32, AXI data width (32 or 64).
- ADDR_WIDTH, 32, AXI address width.
- NUM_VECTORS, 4, number of test vectors / register slots (1..16).
- BASE_ADDR, 32'h0, address of vector 0.
- ADDR_STRIDE, 4, address increment per vector.
- TIMEOUT_CYCLES, 256, maximum cycles allowed per handshake phase.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- vec_wr_en  in  1  load one test vector.
- vec_wr_idx  in  clog2(NUM_VECTORS)  index of the vector being loaded.
- vec_wr_data  in  DATA_WIDTH  vector value.
- start  in  1  single-cycle pulse that starts a run.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  result of the last run.
- err_count  out  8  mismatches plus bad responses plus timeouts, saturating at 255.
- timeout  out  1  sticky: any phase timed out in the last run.
- first_err_idx  out  clog2(NUM_VECTORS)  vector index of the first error.
- first_err_rdata  out  DATA_WIDTH  data read at the first mismatch.
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_WIDTH/3/1/1  write address channel.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel.
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_WIDTH/3/1/1  read address channel.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  read data channel.

Behaviour:
- Reset values:
  - All outputs 0 and pass=0.
  - Vector array cleared to 0.
  - FSM in IDLE.
  - awprot=arprot=3'b000 and wstrb all ones at all times.
- Vector loads:
  - Accepted only in IDLE; ignored while busy.
  - An index >= NUM_VECTORS is ignored.
- FSM states: IDLE, WR, WRESP, RD, RDATA, CHECK, NEXT, FIN.
- IDLE:
  - On start: idx=0, clear err_count, timeout and first_err_*.
  - Set busy=1 on the next cycle and go to WR.
- WR:
  - Assert awvalid and wvalid together.
  - awaddr = BASE_ADDR + idx*ADDR_STRIDE; wdata = vec[idx].
  - Each valid drops on the cycle after its own ready handshake; the channels are independent, either may complete first.
  - Once both channels have completed, go to WRESP.
- WRESP:
  - bready=1.
  - On bvalid: a bresp other than 2'b00 (OKAY) counts an error.
  - Go to RD.
- RD: arvalid=1, same address; on arready go to RDATA.
- RDATA:
  - rready=1.
  - On rvalid, capture rdata; an rresp other than OKAY counts an error.
  - Go to CHECK.
- CHECK:
  - If rdata != vec[idx], count an error.
  - Record first_err_* only if this is the first error of the run.
- NEXT: if idx == NUM_VECTORS-1 go to FIN; otherwise idx+1 and go to WR.
- FIN: done=1 for one cycle; pass=(err_count==0); busy=0; go to IDLE.
- Timeout:
  - Per-phase counter resets on entry to each handshake state.
  - On reaching TIMEOUT_CYCLES: set timeout, count an error, drop all valids/readies and go directly to FIN.
- Latency: with a zero-wait slave, one vector takes 6 cycles.
- Boundaries:
  - Multiple errors on a single vector count separately.
  - start while busy is ignored.
  - ARESET mid-run returns to IDLE immediately with all valids low. Breaking an AXI handshake this way is permitted only together with a slave reset.

Optional Feature:
- Macro AXIL_CHK_HALT_ON_ERR_EN.
- Defined: the first error in CHECK, WRESP or RDATA ends the run at FIN after that vector; remaining vectors are skipped and err_count is 1.
- Undefined: every vector is run and all errors are counted.

Test Plan:
- Load vectors 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011; start against a register-file slave -> 4 writes to 0x0,0x4,0x8,0xC, then done, pass=1, err_count=0.
- Slave with bit 31 of register 2 stuck at 0 -> err_count=1, first_err_idx=2, first_err_rdata=0x5EAD0011, pass=0.
- Slave asserts wready 3 cycles after awready, and arready only after 5 wait cycles -> addresses and data correct, pass=1.
- Slave returns bresp=2'b10 on vector 1 -> err_count=1, pass=0. With AXIL_CHK_HALT_ON_ERR_EN defined, no transactions are issued at 0x8 or 0xC.
- Slave never asserts bvalid, TIMEOUT_CYCLES=16 -> timeout=1, done 16 cycles after entering WRESP, bready low afterwards.
- ARESET asserted during RDATA -> next cycle busy=0, all valids and readies 0. A subsequent start completes normally.
